rd_req_sched: RTL and testbench
===============================

RD_REQ_SCHED -- requirements
Module: rd_req_sched

Interface
REQ-001 SHALL have parameter AW, default 8: request address width.
REQ-002 SHALL have parameter DW, default 16: read data width.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2): request queue entries.
REQ-004 SHALL have parameter TMO, default 15 (≥2): maximum WAIT cycles before timeout.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  in  1  upstream request offer.
REQ-008 SHALL have port req_addr  in  AW  requested read address.
REQ-009 SHALL have port req_ready  out  1  queue can accept (= not full).
REQ-010 SHALL have port go  out  1  start pulse to the read FSM.
REQ-011 SHALL have port addr  out  AW  address of in-flight read, valid from ISSUE through RESP.
REQ-012 SHALL have port rd  in  1  read-phase indication from the read FSM (monitor only).
REQ-013 SHALL have port ds  in  1  done strobe from the read FSM.
REQ-014 SHALL have port rdata  in  DW  read data, valid in the cycle ds=1.
REQ-015 SHALL have port resp_valid  out  1  response available.
REQ-016 SHALL have port resp_ready  in  1  downstream accepts response.
REQ-017 SHALL have port resp_addr  out  AW  address of the response.
REQ-018 SHALL have port resp_data  out  DW  captured data; 0 on error.
REQ-019 SHALL have port resp_err  out  1  timeout flag for this response.
REQ-020 SHALL have port busy  out  1  state != IDLE or queue non-empty.

Function
REQ-021 SHALL hold requests in a DEPTH-entry FIFO with count 0..DEPTH; push on req_valid&&req_ready.
REQ-022 SHALL derive req_ready from registered count only: req_ready=(count<DEPTH); a pop in the same cycle does not enable a push when full.
REQ-023 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-024 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE: count>0 -> ISSUE, latching FIFO head into addr; else stay.
REQ-026 ISSUE: go=1 for exactly this one cycle; next state WAIT unconditionally; ds ignored.
REQ-027 WAIT: timeout counter cleared on entry, +1 per WAIT cycle; ds=1 -> capture rdata, err=0, -> RESP.
REQ-028 WAIT: no ds within TMO cycles (counter reaches TMO-1 without ds) -> data=0, err=1, -> RESP; ds in that same final cycle wins (no error).
REQ-029 RESP: resp_valid=1, resp_addr/data/err stable until resp_ready=1; on handshake pop FIFO head, -> IDLE.
REQ-030 SHALL ignore ds in IDLE, ISSUE and RESP; rd has no effect on state.
REQ-031 Latency: push in cycle N with empty queue and IDLE -> go=1 in cycle N+2; ds in cycle M -> resp_valid=1 in M+1.
REQ-032 SHALL keep the in-flight entry in the FIFO (counted) until its response handshake.
REQ-033 go, resp_valid, busy SHALL be decoded from registered state only (no input-to-output combinational path).

Reset
REQ-034 rst=1 SHALL force state IDLE, count=0, pointers 0, timeout counter 0 on the next edge, including mid-transaction.
REQ-035 Outputs during/after reset: go=0, resp_valid=0, resp_err=0, resp_data=0, resp_addr=0, addr=0, busy=0, req_ready=1.
REQ-036 Requests presented while rst=1 SHALL NOT be queued; a ds arriving after reset SHALL be ignored.

Verification
REQ-037 Single read: push addr 0x12; ds with rdata 0xBEEF 3 cycles after go -> go exactly 1 cycle at N+2, one response addr 0x12, data 0xBEEF, err 0.
REQ-038 Fill: push 5 back-to-back with resp_ready=0 -> 4 accepted, req_ready=0 after 4th, 5th held; responses emerge in order 1..4.
REQ-039 Timeout: go issued, ds never asserted -> resp_valid TMO+1 cycles after go, err=1, data=0; next queued request then issues.
REQ-040 Boundary ds: ds in the last WAIT cycle (TMO-th) -> err=0, data captured.
REQ-041 Backpressure: resp_ready low 10 cycles during RESP -> resp fields stable, no new go, count unchanged; pop on first resp_ready=1.
REQ-042 Reset mid-WAIT: rst for 1 cycle with 3 queued -> all outputs reset values next cycle, count 0, later ds produces no response.

Source files
------------

// File: rtl/rd_req_sched.sv
// Read-request scheduler: queues addresses, launches one read at a time,
// waits for done or timeout, then holds the response until accepted.
module rd_req_sched #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int TMO   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  output logic          req_ready,
  output logic          go,
  output logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          ds,
  input  logic [DW-1:0] rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [AW-1:0] resp_addr,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;
  logic            push, pop;
  logic            unused_rd;

  assign unused_rd  = rd;
  assign req_ready  = (cnt_q < FULL);
  assign push       = req_valid && req_ready;
  assign go         = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  assign addr       = addr_q;
  assign resp_addr  = addr_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = ISSUE;
          addr_d  = mem_q[rptr_q];
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // a strobe in the final wait cycle still beats the timeout
        if (ds) begin
          data_d  = rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TLAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= req_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rd_req_sched.sv
// Randomized bench for rd_req_sched against a timestamp-based
// transaction model of the request queue and read lifecycle.
module tb_rd_req_sched;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;
  localparam int SEGS  = 6;
  localparam int SEGLEN = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          go;
  logic [AW-1:0] addr;
  logic          rd;
  logic          ds;
  logic [DW-1:0] rdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          busy;

  rd_req_sched #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TMO(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .go(go),
    .addr(addr),
    .rd(rd),
    .ds(ds),
    .rdata(rdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_addr(resp_addr),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model: queue holds every accepted address incl. the one in flight;
  // go_at is the cycle number of the current read's go pulse.
  int q[$];
  int go_at;
  bit m_resp;
  int m_addr;
  int m_data;
  bit m_err;
  bit after_rst;

  int pv, pr, pd, prst;
  int mode;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int wait_k();
    return (go_at >= 0 && cyc > go_at) ? cyc - go_at : 0;
  endfunction

  task automatic check_outputs();
    chk("go", 32'(go), 32'(go_at == cyc));
    chk("resp_valid", 32'(resp_valid), 32'(m_resp));
    chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
    chk("busy", 32'(busy),
        32'(q.size() != 0 || go_at >= 0 || m_resp));
    if (go_at >= 0 || m_resp || after_rst)
      chk("addr", 32'(addr), 32'(m_addr));
    if (m_resp || after_rst) begin
      chk("resp_addr", 32'(resp_addr), 32'(m_addr));
      chk("resp_data", 32'(resp_data), 32'(m_data));
      chk("resp_err", 32'(resp_err), 32'(m_err));
    end
  endtask

  task automatic model_step();
    bit idle;
    int size0;
    int k;
    idle  = (go_at < 0) && !m_resp;
    size0 = q.size();
    k     = wait_k();
    if (rst) begin
      q.delete();
      go_at     = -1;
      m_resp    = 1'b0;
      m_addr    = 0;
      m_data    = 0;
      m_err     = 1'b0;
      after_rst = 1'b1;
      return;
    end
    after_rst = 1'b0;
    if (m_resp && resp_ready) begin
      m_resp = 1'b0;
      void'(q.pop_front());
    end else if (idle && size0 > 0) begin
      go_at  = cyc + 1;
      m_addr = q[0];
    end else if (k > 0) begin
      if (ds) begin
        m_resp = 1'b1;
        m_data = int'(rdata);
        m_err  = 1'b0;
        go_at  = -1;
      end else if (k == TMO) begin
        m_resp = 1'b1;
        m_data = 0;
        m_err  = 1'b1;
        go_at  = -1;
      end
    end
    if (req_valid && size0 < DEPTH)
      q.push_back(int'(req_addr));
  endtask

  task automatic drive();
    int k;
    k          = wait_k();
    rst        = ($urandom_range(999) < prst);
    req_valid  = ($urandom_range(99) < pv);
    req_addr   = AW'($urandom);
    resp_ready = ($urandom_range(99) < pr);
    rdata      = DW'($urandom);
    rd         = 1'($urandom);
    if (mode == 3)
      ds = (k == TMO) && ($urandom_range(1) == 1);
    else
      ds = ($urandom_range(99) < pd);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 8'h12;
    rd         = 1'b0;
    ds         = 1'b1;
    rdata      = 16'hBEEF;
    resp_ready = 1'b0;
    go_at      = -1;
    m_resp     = 1'b0;
    m_addr     = 0;
    m_data     = 0;
    m_err      = 1'b0;
    after_rst  = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    for (int s = 0; s < SEGS; s++) begin
      mode = s;
      unique case (s)
        0: begin pv = 60; pr = 70; pd = 30; prst = 3;  end
        1: begin pv = 90; pr = 5;  pd = 40; prst = 2;  end
        2: begin pv = 40; pr = 80; pd = 0;  prst = 2;  end
        3: begin pv = 50; pr = 60; pd = 0;  prst = 2;  end
        4: begin pv = 70; pr = 50; pd = 20; prst = 25; end
        default: begin pv = 30; pr = 90; pd = 50; prst = 3; end
      endcase
      for (int i = 0; i < SEGLEN; i++) begin
        drive();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
